// File: rtl/adxl345_spi_responder_pkg.sv
// ---------------------------------------------------------------------------
// adxl345_spi_responder_pkg
// Shared definitions for the ADXL345 SPI responder and the controller that
// talks to it: register addresses, command-byte field positions and the
// responder FSM state type.
// ---------------------------------------------------------------------------
package adxl345_spi_responder_pkg;

  // Register map (6-bit SPI address space)
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  // Command byte layout: {rw, mb, addr[5:0]}
  localparam int FRAME_RW_BIT   = 7;
  localparam int FRAME_MB_BIT   = 6;
  localparam int FRAME_ADDR_MSB = 5;

  // POWER_CTL bit that enables measurement
  localparam int POWER_CTL_MEASURE_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spiState_e;

endpackage

// File: rtl/adxl345_spi_responder_spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
// Brings one asynchronous SPI line into the clk domain through a STAGES-deep
// flip-flop chain and produces single-cycle rise/fall pulses from the
// synchronized level.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   async_i  in   asynchronous input line
//   rise_o   out  1-cycle pulse on synchronized 0->1
//   fall_o   out  1-cycle pulse on synchronized 1->0
// ---------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic              syncLevel;

  assign syncLevel = chain_q[STAGES-1];

  // Chain and previous level both reset to RESET_VAL so that reset release
  // alone never manufactures an edge when the line sits at that level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= syncLevel;
    end
  end

  assign rise_o = syncLevel & ~prev_q;
  assign fall_o = ~syncLevel & prev_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ---------------------------------------------------------------------------
// adxl345_spi_responder
// SPI mode-3 slave that emulates the ADXL345 register interface so the
// accelerometer controller can run without a real sensor. Frames are
// {rw, mb, addr[5:0]} followed by one or more data bytes. Axis samples are
// injected on parallel ports; completed write bytes are reported on a strobe.
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   CS, SCLK, MOSI           SPI inputs (asynchronous to clk)
//   MISO                     SPI data out, updated after SCLK falling edges
//   sample_x/y/z, sample_valid  axis sample injection (captured on pulse)
//   reg_wr_stb/addr/data     1-cycle report of each completed write byte
//   measure                  POWER_CTL measure bit
//   frame_err                1-cycle pulse when CS rises on a partial frame
// ---------------------------------------------------------------------------
module adxl345_spi_responder
  import adxl345_spi_responder_pkg::*;
#(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        reg_wr_stb,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        measure,
  output logic        frame_err
);

  logic csRise, csFall, sclkRise, sclkFall;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic mosiBit;

  spiState_e   state_q;
  logic        armed_q;
  logic [3:0]  bitCnt_q;
  logic [6:0]  cmdSr_q;
  logic [6:0]  rxSr_q;
  logic [7:0]  txSr_q;
  logic [5:0]  ptr_q;
  logic        rw_q;
  logic        mb_q;
  logic        byteDone_q;
  logic        miso_q;
  logic        wrStb_q;
  logic [5:0]  wrAddr_q;
  logic [7:0]  wrData_q;
  logic        frameErr_q;
  logic        measure_q;

  logic [7:0]  bwRate_q, powerCtl_q, dataFormat_q;
  logic [15:0] liveX_q, liveY_q, liveZ_q;
  logic [15:0] shadowX_q, shadowY_q, shadowZ_q;

  logic [7:0]  cmdByte_d;
  logic [7:0]  rxByte_d;
  logic [5:0]  nextPtr_d;
  logic [7:0]  cmdRdData_d;
  logic [7:0]  nextRdData_d;
  logic        frameComplete_d;

  // CS chain resets to 0 (selected): if CS is already low when reset is
  // released no falling edge appears, so no frame starts until CS has gone
  // high and low again. A rise seen right after reset lands in IDLE unarmed.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (CS),
    .rise_o  (csRise),
    .fall_o  (csFall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (SCLK),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  // MOSI goes through the same depth as SCLK so the bit seen with sclkRise
  // is the one that was on the wire at the SCLK rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosiSync_q <= '0;
    end else begin
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosiBit = mosiSync_q[SYNC_STAGES-1];

  // Read map; axis bytes come from the shadow so a multibyte read is coherent.
  function automatic logic [7:0] regRead(input logic [5:0] addr);
    logic [7:0] val;
    val = 8'h00;
    case (addr)
      ADDR_DEVID:       val = DEVID_VAL;
      ADDR_BW_RATE:     val = bwRate_q;
      ADDR_POWER_CTL:   val = powerCtl_q;
      ADDR_DATA_FORMAT: val = dataFormat_q;
      ADDR_DATAX0:      val = shadowX_q[7:0];
      ADDR_DATAX1:      val = shadowX_q[15:8];
      ADDR_DATAY0:      val = shadowY_q[7:0];
      ADDR_DATAY1:      val = shadowY_q[15:8];
      ADDR_DATAZ0:      val = shadowZ_q[7:0];
      ADDR_DATAZ1:      val = shadowZ_q[15:8];
      default:          val = 8'h00;
    endcase
    return val;
  endfunction

  always_comb begin
    cmdByte_d    = {cmdSr_q, mosiBit};
    rxByte_d     = {rxSr_q, mosiBit};
    nextPtr_d    = ptr_q + 6'd1;
    cmdRdData_d  = regRead(cmdByte_d[FRAME_ADDR_MSB:0]);
    nextRdData_d = regRead(nextPtr_d);
    // A frame is whole when CS rises on a byte boundary after at least one
    // data byte (16 + 8k bits); DONE is only reached after a full byte.
    frameComplete_d = (state_q == ST_DONE) ||
                      ((state_q == ST_DATA) && byteDone_q && (bitCnt_q == 4'd0));
  end

  // Live sample registers follow sample_valid at any time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      liveX_q <= '0;
      liveY_q <= '0;
      liveZ_q <= '0;
    end else if (sample_valid) begin
      liveX_q <= sample_x;
      liveY_q <= sample_y;
      liveZ_q <= sample_z;
    end
  end

  // Frame FSM, shift registers, register file and write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      bitCnt_q     <= '0;
      cmdSr_q      <= '0;
      rxSr_q       <= '0;
      txSr_q       <= '0;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      mb_q         <= 1'b0;
      byteDone_q   <= 1'b0;
      miso_q       <= 1'b0;
      wrStb_q      <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      frameErr_q   <= 1'b0;
      bwRate_q     <= BW_RATE_RST;
      powerCtl_q   <= '0;
      dataFormat_q <= '0;
      shadowX_q    <= '0;
      shadowY_q    <= '0;
      shadowZ_q    <= '0;
    end else begin
      wrStb_q    <= 1'b0;
      frameErr_q <= 1'b0;
      if (csRise) begin
        // Any partial byte is simply dropped; completed bytes were committed.
        if (armed_q && !frameComplete_d) begin
          frameErr_q <= 1'b1;
        end
        state_q  <= ST_IDLE;
        armed_q  <= 1'b0;
        miso_q   <= 1'b0;
        bitCnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (csFall) begin
              state_q    <= ST_CMD;
              armed_q    <= 1'b1;
              bitCnt_q   <= '0;
              byteDone_q <= 1'b0;
              miso_q     <= 1'b0;
              shadowX_q  <= liveX_q;
              shadowY_q  <= liveY_q;
              shadowZ_q  <= liveZ_q;
            end
          end
          ST_CMD: begin
            if (sclkRise) begin
              cmdSr_q  <= cmdByte_d[6:0];
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                state_q  <= ST_DATA;
                bitCnt_q <= '0;
                rw_q     <= cmdByte_d[FRAME_RW_BIT];
                mb_q     <= cmdByte_d[FRAME_MB_BIT];
                ptr_q    <= cmdByte_d[FRAME_ADDR_MSB:0];
                txSr_q   <= cmdByte_d[FRAME_RW_BIT] ? cmdRdData_d : 8'h00;
              end
            end
          end
          ST_DATA: begin
            if (sclkFall) begin
              miso_q <= txSr_q[7];
              txSr_q <= {txSr_q[6:0], 1'b0};
            end
            if (sclkRise) begin
              rxSr_q   <= rxByte_d[6:0];
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                bitCnt_q   <= '0;
                byteDone_q <= 1'b1;
                if (!rw_q) begin
                  // Strobe reports every write byte, even to read-only space.
                  wrStb_q  <= 1'b1;
                  wrAddr_q <= ptr_q;
                  wrData_q <= rxByte_d;
                  case (ptr_q)
                    ADDR_BW_RATE:     bwRate_q     <= rxByte_d;
                    ADDR_POWER_CTL:   powerCtl_q   <= rxByte_d;
                    ADDR_DATA_FORMAT: dataFormat_q <= rxByte_d;
                    default: ;
                  endcase
                end
                if (mb_q) begin
                  ptr_q  <= nextPtr_d;
                  txSr_q <= rw_q ? nextRdData_d : 8'h00;
                end else begin
                  state_q <= ST_DONE;
                  miso_q  <= 1'b0;
                end
              end
            end
          end
          ST_DONE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // measure trails POWER_CTL by one clock, i.e. the clock after reg_wr_stb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      measure_q <= 1'b0;
    end else begin
      measure_q <= powerCtl_q[POWER_CTL_MEASURE_BIT];
    end
  end

  assign MISO        = miso_q;
  assign reg_wr_stb  = wrStb_q;
  assign reg_wr_addr = wrAddr_q;
  assign reg_wr_data = wrData_q;
  assign measure     = measure_q;
  assign frame_err   = frameErr_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adxl345_spi_responder
// Self-checking bench: drives SPI mode-3 frames and sample injections, and
// compares against a register-map model kept as plain arrays.
// ---------------------------------------------------------------------------
module tb_adxl345_spi_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        reg_wr_stb;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        measure;
  logic        frame_err;

  int passCount  = 0;
  int checkCount = 0;

  logic [5:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  int         frameErrCount = 0;

  logic [7:0] mdlReg    [0:63];
  logic [7:0] mdlSample [0:5];

  adxl345_spi_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .CS           (CS),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .reg_wr_stb   (reg_wr_stb),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .measure      (measure),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Record every cycle the strobes are high; a stretched pulse shows up as
  // extra entries.
  always @(negedge clk) begin
    if (reg_wr_stb) begin
      wrAddrQ.push_back(reg_wr_addr);
      wrDataQ.push_back(reg_wr_data);
    end
    if (frame_err) frameErrCount++;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdlReg[i] = 8'h00;
    mdlReg[6'h00] = 8'hE5;
    mdlReg[6'h2C] = 8'h0A;
    for (int i = 0; i < 6; i++) mdlSample[i] = 8'h00;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [7:0] d);
    if (a == 6'h2C || a == 6'h2D || a == 6'h31) mdlReg[a] = d;
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    int idx;
    idx = int'(a);
    if (idx >= 'h32 && idx <= 'h37) return mdlSample[idx - 'h32];
    return mdlReg[a];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_samples(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    mdlSample[0] = x[7:0];
    mdlSample[1] = x[15:8];
    mdlSample[2] = y[7:0];
    mdlSample[3] = y[15:8];
    mdlSample[4] = z[7:0];
    mdlSample[5] = z[15:8];
  endtask

  // Sends the low nBits of txBits MSB first; MISO is captured just before
  // each rising SCLK edge, as the master would.
  task automatic spi_frame(input int nBits, input logic [63:0] txBits, output logic [63:0] rxBits);
    rxBits = '0;
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      SCLK = 1'b0;
      MOSI = txBits[nBits-1-i];
      repeat (HALF) @(negedge clk);
      rxBits = {rxBits[62:0], MISO};
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic spi_read(input logic [5:0] a, output logic [7:0] d);
    logic [63:0] rx;
    spi_frame(16, {48'h0, 2'b10, a, 8'h00}, rx);
    d = rx[7:0];
  endtask

  task automatic spi_write(input logic [5:0] a, input logic [7:0] d);
    logic [63:0] rx;
    spi_frame(16, {48'h0, 2'b00, a, d}, rx);
    model_write(a, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd;
    reset_n = 1'b0;
    CS = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    sample_valid = 1'b0;
    sample_x = '0;
    sample_y = '0;
    sample_z = '0;
    model_reset();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checkCount++; if (MISO !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", MISO); else passCount++;
    checkCount++; if (reg_wr_stb !== 1'b0) $display("[TB] FAIL reset_stb: got %b expected 0", reg_wr_stb); else passCount++;
    checkCount++; if (reg_wr_addr !== 6'h00) $display("[TB] FAIL reset_addr: got %h expected 00", reg_wr_addr); else passCount++;
    checkCount++; if (reg_wr_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", reg_wr_data); else passCount++;
    checkCount++; if (measure !== 1'b0) $display("[TB] FAIL reset_measure: got %b expected 0", measure); else passCount++;
    checkCount++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); else passCount++;
    spi_read(6'h2C, rd);
    checkCount++; if (rd !== model_read(6'h2C)) $display("[TB] FAIL reset_bw_rate: got %h expected %h", rd, model_read(6'h2C)); else passCount++;
    spi_read(6'h32, rd);
    checkCount++; if (rd !== 8'h00) $display("[TB] FAIL reset_datax0: got %h expected 00", rd); else passCount++;
  endtask

  task automatic test_devid();
    logic [63:0] rx;
    wrAddrQ.delete();
    wrDataQ.delete();
    spi_frame(16, 64'h8000, rx);
    checkCount++; if (rx[7:0] !== 8'hE5) $display("[TB] FAIL devid_data: got %h expected e5", rx[7:0]); else passCount++;
    checkCount++; if (rx[15:8] !== 8'h00) $display("[TB] FAIL devid_cmd_miso: got %h expected 00", rx[15:8]); else passCount++;
    checkCount++; if (wrAddrQ.size() != 0) $display("[TB] FAIL devid_no_write: got %0d strobes expected 0", wrAddrQ.size()); else passCount++;
    checkCount++; if (MISO !== 1'b0) $display("[TB] FAIL devid_miso_idle: got %b expected 0", MISO); else passCount++;
  endtask

  task automatic test_write_measure();
    logic [7:0] rd;
    logic [5:0] a;
    logic [7:0] d;
    wrAddrQ.delete();
    wrDataQ.delete();
    spi_write(6'h2D, 8'h08);
    checkCount++; if (wrAddrQ.size() != 1) $display("[TB] FAIL pc_write_count: got %0d expected 1", wrAddrQ.size()); else passCount++;
    if (wrAddrQ.size() > 0) begin
      checkCount++; if (wrAddrQ[0] !== 6'h2D) $display("[TB] FAIL pc_write_addr: got %h expected 2d", wrAddrQ[0]); else passCount++;
      checkCount++; if (wrDataQ[0] !== 8'h08) $display("[TB] FAIL pc_write_data: got %h expected 08", wrDataQ[0]); else passCount++;
    end
    checkCount++; if (measure !== 1'b1) $display("[TB] FAIL pc_measure: got %b expected 1", measure); else passCount++;
    spi_read(6'h2D, rd);
    checkCount++; if (rd !== 8'h08) $display("[TB] FAIL pc_readback: got %h expected 08", rd); else passCount++;
    for (int k = 0; k < 8; k++) begin
      a = 6'($urandom_range(0, 63));
      if (k < 3) a = (k == 0) ? 6'h2C : ((k == 1) ? 6'h31 : 6'h2D);
      d = 8'($urandom);
      wrAddrQ.delete();
      wrDataQ.delete();
      spi_write(a, d);
      checkCount++;
      if (wrAddrQ.size() != 1 || wrAddrQ[0] !== a || wrDataQ[0] !== d)
        $display("[TB] FAIL rand_write_strobe: got count %0d expected 1 with addr %h data %h", wrAddrQ.size(), a, d);
      else passCount++;
      checkCount++; if (measure !== mdlReg[6'h2D][3]) $display("[TB] FAIL rand_measure: got %b expected %b", measure, mdlReg[6'h2D][3]); else passCount++;
      spi_read(a, rd);
      checkCount++; if (rd !== model_read(a)) $display("[TB] FAIL rand_readback addr %h: got %h expected %h", a, rd, model_read(a)); else passCount++;
    end
  endtask

  task automatic test_multibyte();
    logic [63:0] rx;
    logic [47:0] exp;
    logic [15:0] y, z;
    for (int k = 0; k < 3; k++) begin
      y = 16'($urandom);
      z = 16'($urandom);
      set_samples((k == 0) ? 16'h1234 : 16'($urandom), y, z);
      wrAddrQ.delete();
      spi_frame(56, {8'h0, 8'hF2, 48'h0}, rx);
      exp = '0;
      for (int b = 0; b < 6; b++) exp = {exp[39:0], model_read(6'(6'h32 + b))};
      checkCount++; if (rx[47:0] !== exp) $display("[TB] FAIL mb_read_xyz: got %h expected %h", rx[47:0], exp); else passCount++;
      checkCount++; if (wrAddrQ.size() != 0) $display("[TB] FAIL mb_read_no_write: got %0d expected 0", wrAddrQ.size()); else passCount++;
    end
    // Pointer wraps from 0x3F to 0x00
    spi_frame(24, {40'h0, 8'hFF, 16'h0}, rx);
    exp = {32'h0, model_read(6'h3F), model_read(6'h00)};
    checkCount++; if (rx[15:0] !== exp[15:0]) $display("[TB] FAIL mb_wrap: got %h expected %h", rx[15:0], exp[15:0]); else passCount++;
  endtask

  task automatic test_sample_mid();
    logic [63:0] rx;
    logic [47:0] expOld, expNew;
    set_samples(16'($urandom), 16'($urandom), 16'($urandom));
    expOld = '0;
    for (int b = 0; b < 6; b++) expOld = {expOld[39:0], mdlSample[b]};
    fork
      spi_frame(56, {8'h0, 8'hF2, 48'h0}, rx);
      begin
        repeat (300) @(negedge clk);
        set_samples(16'($urandom), 16'($urandom), 16'($urandom));
      end
    join
    checkCount++; if (rx[47:0] !== expOld) $display("[TB] FAIL mid_sample_old: got %h expected %h", rx[47:0], expOld); else passCount++;
    expNew = '0;
    for (int b = 0; b < 6; b++) expNew = {expNew[39:0], mdlSample[b]};
    spi_frame(56, {8'h0, 8'hF2, 48'h0}, rx);
    checkCount++; if (rx[47:0] !== expNew) $display("[TB] FAIL mid_sample_new: got %h expected %h", rx[47:0], expNew); else passCount++;
  endtask

  task automatic test_frame_err();
    logic [63:0] rx;
    logic [7:0]  rd;
    int          errBase;
    errBase = frameErrCount;
    wrAddrQ.delete();
    wrDataQ.delete();
    spi_frame(11, 64'h2C55 >> 5, rx);
    checkCount++; if (frameErrCount != errBase + 1) $display("[TB] FAIL ferr_pulse: got %0d pulses expected 1", frameErrCount - errBase); else passCount++;
    checkCount++; if (wrAddrQ.size() != 0) $display("[TB] FAIL ferr_no_write: got %0d expected 0", wrAddrQ.size()); else passCount++;
    spi_read(6'h2C, rd);
    checkCount++; if (rd !== model_read(6'h2C)) $display("[TB] FAIL ferr_bw_kept: got %h expected %h", rd, model_read(6'h2C)); else passCount++;
    spi_write(6'h2C, 8'h0F);
    checkCount++;
    if (wrAddrQ.size() != 1 || wrAddrQ[0] !== 6'h2C || wrDataQ[0] !== 8'h0F)
      $display("[TB] FAIL ferr_next_write: got count %0d expected 1 with addr 2c data 0f", wrAddrQ.size());
    else passCount++;
    checkCount++; if (frameErrCount != errBase + 1) $display("[TB] FAIL ferr_clean_frames: got %0d pulses expected 1", frameErrCount - errBase); else passCount++;
    spi_read(6'h2C, rd);
    checkCount++; if (rd !== 8'h0F) $display("[TB] FAIL ferr_readback: got %h expected 0f", rd); else passCount++;
    // Command byte alone is also incomplete
    spi_frame(8, 64'h80, rx);
    checkCount++; if (frameErrCount != errBase + 2) $display("[TB] FAIL ferr_cmd_only: got %0d pulses expected 2", frameErrCount - errBase); else passCount++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] tx;
    logic [7:0]  rd;
    int          errBase;
    tx = 16'h3107;
    spi_write(6'h2D, 8'h08);
    errBase = frameErrCount;
    wrAddrQ.delete();
    wrDataQ.delete();
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      SCLK = 1'b0;
      MOSI = tx[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i == 4) begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
      end
    end
    repeat (2*HALF) @(negedge clk);
    checkCount++; if (wrAddrQ.size() != 0) $display("[TB] FAIL rstmid_no_write: got %0d expected 0", wrAddrQ.size()); else passCount++;
    checkCount++; if (measure !== 1'b0) $display("[TB] FAIL rstmid_measure: got %b expected 0", measure); else passCount++;
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (2*HALF) @(negedge clk);
    checkCount++; if (frameErrCount != errBase) $display("[TB] FAIL rstmid_no_ferr: got %0d pulses expected 0", frameErrCount - errBase); else passCount++;
    spi_read(6'h2C, rd);
    checkCount++; if (rd !== 8'h0A) $display("[TB] FAIL rstmid_bw_reset: got %h expected 0a", rd); else passCount++;
    spi_write(6'h31, 8'h07);
    checkCount++;
    if (wrAddrQ.size() != 1 || wrAddrQ[0] !== 6'h31 || wrDataQ[0] !== 8'h07)
      $display("[TB] FAIL rstmid_fresh_write: got count %0d expected 1 with addr 31 data 07", wrAddrQ.size());
    else passCount++;
    spi_read(6'h31, rd);
    checkCount++; if (rd !== 8'h07) $display("[TB] FAIL rstmid_readback: got %h expected 07", rd); else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] rx;
    logic [7:0]  d [0:2];
    logic [7:0]  rd;
    logic [5:0]  ea;
    for (int b = 0; b < 3; b++) d[b] = 8'($urandom);
    wrAddrQ.delete();
    wrDataQ.delete();
    spi_frame(32, {32'h0, 8'h6C, d[0], d[1], d[2]}, rx);
    for (int b = 0; b < 3; b++) model_write(6'(6'h2C + b), d[b]);
    checkCount++; if (wrAddrQ.size() != 3) $display("[TB] FAIL mbw_count: got %0d expected 3", wrAddrQ.size()); else passCount++;
    for (int b = 0; b < 3 && b < wrAddrQ.size(); b++) begin
      ea = 6'(6'h2C + b);
      checkCount++;
      if (wrAddrQ[b] !== ea || wrDataQ[b] !== d[b])
        $display("[TB] FAIL mbw_byte%0d: got %h/%h expected %h/%h", b, wrAddrQ[b], wrDataQ[b], ea, d[b]);
      else passCount++;
    end
    checkCount++; if (measure !== mdlReg[6'h2D][3]) $display("[TB] FAIL mbw_measure: got %b expected %b", measure, mdlReg[6'h2D][3]); else passCount++;
    spi_read(6'h2C, rd);
    checkCount++; if (rd !== model_read(6'h2C)) $display("[TB] FAIL mbw_rb_2c: got %h expected %h", rd, model_read(6'h2C)); else passCount++;
    spi_read(6'h2D, rd);
    checkCount++; if (rd !== model_read(6'h2D)) $display("[TB] FAIL mbw_rb_2d: got %h expected %h", rd, model_read(6'h2D)); else passCount++;
    spi_read(6'h2E, rd);
    checkCount++; if (rd !== 8'h00) $display("[TB] FAIL mbw_rb_2e: got %h expected 00", rd); else passCount++;
  endtask

  initial begin
    test_reset();
    test_devid();
    test_write_measure();
    test_multibyte();
    test_sample_mid();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
